gb_xfer_monitor: RTL and testbench

//   Synthesisable traffic monitor for the global buffer (GB) interfaces. It counts accepted
//   val&rdy beats on NUM_CH channels (default: wei data, wei flag, wei instr, act data, act flag).
//   On a pullback pulse for a channel's group, it closes that channel's epoch count into a record.

---
 rtl/gb_xfer_monitor.sv | 147 ++++++++++++++
 tb/tb_gb_xfer_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gb_xfer_monitor.sv
// Global-buffer traffic monitor: per-channel accepted-beat counters closed into
// {ovf, id, count} records by group pullbacks, queued in a show-ahead FIFO.
module gb_xfer_monitor #(
  parameter int                      NUM_CH     = 5,
  parameter int                      NUM_GRP    = 2,
  parameter int                      GRP_W      = 1,
  parameter logic [NUM_CH*GRP_W-1:0] CH_GRP     = 5'b11000,
  parameter int                      CNT_WIDTH  = 32,
  parameter int                      FIFO_DEPTH = 8,
  parameter int                      ID_W       = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NUM_CH-1:0]           ch_val,
  input  logic [NUM_CH-1:0]           ch_rdy,
  input  logic [NUM_GRP-1:0]          pullback,
  output logic                        rec_val,
  input  logic                        rec_rdy,
  output logic [ID_W+CNT_WIDTH:0]     rec_data,
  output logic [15:0]                 drop_cnt,
  output logic                        busy
);

  localparam int REC_W = 1 + ID_W + CNT_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [NUM_CH-1:0]    beat_s;
  logic [NUM_CH-1:0]    close_s;
  logic [NUM_CH-1:0]    drain_s;
  logic [NUM_CH-1:0]    drop_s;
  logic [CNT_WIDTH-1:0] cnt_r  [NUM_CH];
  logic [REC_W-1:0]     snap_r [NUM_CH];
  logic [NUM_CH-1:0]    ovf_r;
  logic [NUM_CH-1:0]    pend_r;
  logic [ID_W-1:0]      sel_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 empty_s;
  logic [REC_W-1:0]     mem_r [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_r;
  logic [AW:0]          rd_ptr_r;
  logic [4:0]           drop_num_s;
  logic [16:0]          drop_sum_s;
  logic [15:0]          drop_cnt_r;

  // Beat qualification and mapping of group pullbacks onto channels
  always_comb begin
    beat_s  = ch_val & ch_rdy & {NUM_CH{enable}};
    close_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      for (int g = 0; g < NUM_GRP; g++) begin
        close_s[i] = close_s[i] | (pullback[g] & (CH_GRP[i*GRP_W +: GRP_W] == GRP_W'(g)));
      end
    end
  end

  // FIFO status flags from the extra pointer MSB
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  end

  // Lowest-index pending channel wins the single push slot; a pop frees room the same cycle
  always_comb begin
    sel_s = {ID_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      sel_s = pend_r[i] ? ID_W'(i) : sel_s;
    end
    pop_s  = ~empty_s & rec_rdy;
    push_s = (|pend_r) & (~full_s | pop_s);
    for (int i = 0; i < NUM_CH; i++) begin
      drain_s[i] = push_s & (sel_s == ID_W'(i));
    end
    drop_s     = close_s & pend_r & ~drain_s;
    drop_num_s = 5'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      drop_num_s = drop_num_s + {4'd0, drop_s[i]};
    end
    drop_sum_s = {1'b0, drop_cnt_r} + {12'd0, drop_num_s};
  end

  // Per-channel epoch counters, sticky overflow and snapshot/pending registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r  <= {NUM_CH{1'b0}};
      pend_r <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i]  <= {CNT_WIDTH{1'b0}};
        snap_r[i] <= {REC_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (close_s[i]) begin
          // A beat coinciding with the close is the first beat of the new epoch
          snap_r[i] <= {ovf_r[i], ID_W'(i), cnt_r[i]};
          pend_r[i] <= 1'b1;
          cnt_r[i]  <= beat_s[i] ? CNT_WIDTH'(1'b1) : {CNT_WIDTH{1'b0}};
          ovf_r[i]  <= 1'b0;
        end else begin
          if (drain_s[i]) begin
            pend_r[i] <= 1'b0;
          end
          if (beat_s[i]) begin
            if (cnt_r[i] == CNT_MAX) begin
              ovf_r[i] <= 1'b1;
            end else begin
              cnt_r[i] <= cnt_r[i] + CNT_WIDTH'(1'b1);
            end
          end
        end
      end
    end
  end

  // FIFO pointers and saturating record-loss counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      drop_cnt_r <= 16'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1'b1);
      end
      drop_cnt_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end
  end

  // Record storage; contents are don't-care until the pointers cover them
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= snap_r[sel_s];
    end
  end

  assign rec_val  = ~empty_s;
  assign rec_data = empty_s ? {REC_W{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];
  assign busy     = (|pend_r) | ~empty_s;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_gb_xfer_monitor.sv
// Directed bench for gb_xfer_monitor: a default instance and a narrow-counter,
// shallow-FIFO instance, each checked against hand-computed records.
module tb_gb_xfer_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [4:0]  ch_val = 5'd0;
  logic [4:0]  ch_rdy = 5'd0;
  logic [1:0]  pullback = 2'd0;
  logic        rec_val;
  logic        rec_rdy = 1'b0;
  logic [35:0] rec_data;
  logic [15:0] drop_cnt;
  logic        busy;

  logic        s_enable = 1'b0;
  logic [4:0]  s_ch_val = 5'd0;
  logic [4:0]  s_ch_rdy = 5'd0;
  logic [1:0]  s_pullback = 2'd0;
  logic        s_rec_val;
  logic        s_rec_rdy = 1'b0;
  logic [7:0]  s_rec_data;
  logic [15:0] s_drop_cnt;
  logic        s_busy;

  int n_assert = 0;
  int n_fail   = 0;
  int epoch;
  int phase;
  int popped;
  logic [7:0] exp_q[$];

  gb_xfer_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_val(ch_val), .ch_rdy(ch_rdy),
    .pullback(pullback), .rec_val(rec_val), .rec_rdy(rec_rdy), .rec_data(rec_data),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  gb_xfer_monitor #(.CNT_WIDTH(4), .FIFO_DEPTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .enable(s_enable), .ch_val(s_ch_val), .ch_rdy(s_ch_rdy),
    .pullback(s_pullback), .rec_val(s_rec_val), .rec_rdy(s_rec_rdy), .rec_data(s_rec_data),
    .drop_cnt(s_drop_cnt), .busy(s_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] mk(input logic ovf, input logic [2:0] id, input logic [31:0] c);
    return {ovf, id, c};
  endfunction

  function automatic logic [7:0] mks(input logic ovf, input logic [2:0] id, input logic [3:0] c);
    return {ovf, id, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a record, check it, then pop it with a one-cycle ready
  task automatic pop_rec(input bit sm, input logic [35:0] exp, input string tag);
    int n = 0;
    while (((sm ? s_rec_val : rec_val) !== 1'b1) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_val"}, sm ? s_rec_val : rec_val, 1'b1);
    chk(tag, sm ? {28'd0, s_rec_data} : rec_data, exp);
    if (sm) s_rec_rdy = 1'b1;
    else    rec_rdy = 1'b1;
    tick();
    s_rec_rdy = 1'b0;
    rec_rdy   = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_rec_val", rec_val, 1'b0);
    chk("rst_rec_data", rec_data, 36'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", drop_cnt, 16'd0);
    chk("rst_s_rec_val", s_rec_val, 1'b0);
    chk("rst_s_busy", s_busy, 1'b0);
    rst_n = 1'b1;
    enable = 1'b1;
    s_enable = 1'b1;
    tick();

    // T1: ch0 7 beats, ch3 4 beats, ch4 3 beats; val without rdy must not count
    ch_val = 5'b00111; ch_rdy = 5'b00000; tick();
    ch_val = 5'b11001; ch_rdy = 5'b11001; repeat (3) tick();
    ch_val = 5'b01001; ch_rdy = 5'b01001; tick();
    ch_val = 5'b00001; ch_rdy = 5'b00001; repeat (3) tick();
    ch_val = 5'd0; ch_rdy = 5'd0;
    pullback = 2'b01; tick(); pullback = 2'b00;
    chk("t1_lat_val0", rec_val, 1'b0);
    chk("t1_lat_busy", busy, 1'b1);
    tick();
    chk("t1_lat_val1", rec_val, 1'b1);
    pop_rec(1'b0, mk(1'b0, 3'd0, 32'd7), "t1_ch0");
    pop_rec(1'b0, mk(1'b0, 3'd1, 32'd0), "t1_ch1");
    pop_rec(1'b0, mk(1'b0, 3'd2, 32'd0), "t1_ch2");
    chk("t1_idle_val", rec_val, 1'b0);
    chk("t1_idle_busy", busy, 1'b0);

    // T2: ch3 beat coincides with pullback[1]
    ch_val = 5'b01000; ch_rdy = 5'b01000; pullback = 2'b10; tick();
    ch_val = 5'd0; ch_rdy = 5'd0; pullback = 2'b00;
    pop_rec(1'b0, mk(1'b0, 3'd3, 32'd4), "t2_ch3_a");
    pop_rec(1'b0, mk(1'b0, 3'd4, 32'd3), "t2_ch4_a");
    pullback = 2'b10; tick(); pullback = 2'b00;
    pop_rec(1'b0, mk(1'b0, 3'd3, 32'd1), "t2_ch3_b");
    pop_rec(1'b0, mk(1'b0, 3'd4, 32'd0), "t2_ch4_b");

    // enable=0 ignores beats
    enable = 1'b0; ch_val = 5'b00001; ch_rdy = 5'b00001; repeat (5) tick();
    enable = 1'b1; repeat (2) tick();
    ch_val = 5'd0; ch_rdy = 5'd0;
    pullback = 2'b01; tick(); pullback = 2'b00;
    pop_rec(1'b0, mk(1'b0, 3'd0, 32'd2), "en_ch0");
    pop_rec(1'b0, mk(1'b0, 3'd1, 32'd0), "en_ch1");
    pop_rec(1'b0, mk(1'b0, 3'd2, 32'd0), "en_ch2");

    // T3: 4-bit counter saturates with sticky ovf; next epoch clean
    s_ch_val = 5'b00010; s_ch_rdy = 5'b00010; repeat (20) tick();
    s_ch_val = 5'd0; s_ch_rdy = 5'd0;
    s_pullback = 2'b01; tick(); s_pullback = 2'b00;
    pop_rec(1'b1, {28'd0, mks(1'b0, 3'd0, 4'd0)}, "t3_ch0");
    pop_rec(1'b1, {28'd0, mks(1'b1, 3'd1, 4'd15)}, "t3_ch1_sat");
    pop_rec(1'b1, {28'd0, mks(1'b0, 3'd2, 4'd0)}, "t3_ch2");
    s_pullback = 2'b01; tick(); s_pullback = 2'b00;
    pop_rec(1'b1, {28'd0, mks(1'b0, 3'd0, 4'd0)}, "t3_ch0_b");
    pop_rec(1'b1, {28'd0, mks(1'b0, 3'd1, 4'd0)}, "t3_ch1_clr");
    pop_rec(1'b1, {28'd0, mks(1'b0, 3'd2, 4'd0)}, "t3_ch2_b");

    // T5: random backpressure over many FIFO wraps, depth 4
    epoch = 0; phase = 0; popped = 0;
    for (int cyc = 0; cyc < 4000 && popped < 201; cyc++) begin
      if (epoch < 67) begin
        for (int i = 0; i < 3; i++) s_ch_val[i] = (phase < ((epoch + 5 * i) % 15));
        s_ch_rdy = s_ch_val;
        s_pullback = (phase == 20) ? 2'b01 : 2'b00;
        if (phase == 20) begin
          for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 3'(i), 4'((epoch + 5 * i) % 15)});
        end
        phase++;
        if (phase == 24) begin
          phase = 0;
          epoch++;
        end
      end else begin
        s_ch_val = 5'd0; s_ch_rdy = 5'd0; s_pullback = 2'b00;
      end
      s_rec_rdy = ($urandom_range(0, 3) != 0);
      if (s_rec_val) begin
        if (exp_q.size() == 0) chk("t5_extra", s_rec_val, 1'b0);
        else begin
          chk("t5_data", s_rec_data, exp_q[0]);
          if (s_rec_rdy) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
      tick();
    end
    s_rec_rdy = 1'b0; s_pullback = 2'b00; s_ch_val = 5'd0; s_ch_rdy = 5'd0;
    chk("t5_count", popped, 201);
    chk("t5_drop", s_drop_cnt, 16'd0);
    tick();
    chk("t5_busy", s_busy, 1'b0);

    // T4: stall the consumer, fill FIFO, force pend overwrites
    rec_rdy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      ch_val = 5'b00101; ch_rdy = 5'b00101; repeat (k) tick();
      ch_val = 5'd0; ch_rdy = 5'd0;
      pullback = 2'b01; tick(); pullback = 2'b00;
      if (k == 4) chk("t4_drop_1", drop_cnt, 16'd1);
      repeat (3) tick();
    end
    chk("t4_drop_4", drop_cnt, 16'd4);
    chk("t4_hold_val", rec_val, 1'b1);
    chk("t4_hold_data", rec_data, mk(1'b0, 3'd0, 32'd1));
    chk("t4_busy", busy, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      pop_rec(1'b0, mk(1'b0, 3'd0, k), "t4_ch0");
      pop_rec(1'b0, mk(1'b0, 3'd1, 32'd0), "t4_ch1");
      if (k < 3) pop_rec(1'b0, mk(1'b0, 3'd2, k), "t4_ch2");
    end
    pop_rec(1'b0, mk(1'b0, 3'd0, 32'd5), "t4_e0");
    pop_rec(1'b0, mk(1'b0, 3'd1, 32'd0), "t4_e1");
    pop_rec(1'b0, mk(1'b0, 3'd2, 32'd5), "t4_e2");
    chk("t4_empty", busy, 1'b0);
    chk("t4_drop_keep", drop_cnt, 16'd4);

    // T6: reset with two records queued, one pending, ch0 mid-count
    pullback = 2'b01; tick(); pullback = 2'b00;
    ch_val = 5'b00001; ch_rdy = 5'b00001; tick(); tick();
    chk("t6_pre_val", rec_val, 1'b1);
    chk("t6_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_val", rec_val, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_drop", drop_cnt, 16'd0);
    chk("t6_rst_data", rec_data, 36'd0);
    ch_val = 5'd0; ch_rdy = 5'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    ch_val = 5'b00001; ch_rdy = 5'b00001; repeat (3) tick();
    ch_val = 5'd0; ch_rdy = 5'd0;
    pullback = 2'b01; tick(); pullback = 2'b00;
    pop_rec(1'b0, mk(1'b0, 3'd0, 32'd3), "t6_ch0");
    pop_rec(1'b0, mk(1'b0, 3'd1, 32'd0), "t6_ch1");
    pop_rec(1'b0, mk(1'b0, 3'd2, 32'd0), "t6_ch2");
    chk("t6_end_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
